// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the MEM-stage load queue.
//   mt_size_e    : mem_type[1:0] access-size encodings
//   MT_UNSIGNED  : bit index of the unsigned flag in mem_type
//   mq_entry_t   : per-slot bookkeeping of mem_load_queue (payload kept separately
//                  because its width is a module parameter)
package mem_pkg;

   typedef enum logic [1:0] {
      MT_HALF = 2'b01,
      MT_BYTE = 2'b10,
      MT_WORD = 2'b11
   } mt_size_e;

   localparam int unsigned MT_UNSIGNED = 2;

   typedef struct packed {
      logic        valid;     // slot holds a live request
      logic        arrived;   // data_ok for this request has been seen
      logic        load;      // 1 = load, 0 = store
      logic [2:0]  mtype;     // mem_type as issued in EX
      logic [1:0]  addr_low;  // address bits [1:0]
      logic [31:0] data;      // raw SRAM word captured at data_ok
   } mq_entry_t;

endpackage

// File: rtl/mem_load_queue_load_ext.sv
// load_ext: combinational load aligner / extender.
//   mtype    in  3   mem_type ([1:0] size, [2] unsigned)
//   addr_low in  2   address bits [1:0]
//   rdata    in  32  raw SRAM word
//   data     out 32  aligned, sign/zero-extended load result (word passes through)
module load_ext
   import mem_pkg::*;
(
   input  logic [2:0]  mtype,
   input  logic [1:0]  addr_low,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [15:0] half_v;
   logic [7:0]  byte_v;
   logic        sext;

   always_comb begin
      half_v = addr_low[1] ? rdata[31:16] : rdata[15:0];
      case (addr_low)
         2'd0:    byte_v = rdata[7:0];
         2'd1:    byte_v = rdata[15:8];
         2'd2:    byte_v = rdata[23:16];
         default: byte_v = rdata[31:24];
      endcase
      sext = ~mtype[MT_UNSIGNED];
      case (mtype[1:0])
         MT_HALF: data = {{16{sext & half_v[15]}}, half_v};
         MT_BYTE: data = {{24{sext & byte_v[7]}}, byte_v};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_load_queue.sv
// mem_load_queue: MEM-stage tracker for up to DEPTH outstanding data-SRAM requests.
// Requests accepted in EX are queued in order; in-order data_ok responses are matched
// to them, held while WB stalls, and responses for requests cancelled by a flush are
// silently discarded.
//
// Parameters: DEPTH (power of two, >= 2), INFO_W (opaque payload width).
// Ports:
//   clk, reset (async, active-high)
//   req_push/req_ready/req_load/req_type/req_addr_low/req_info : EX request side
//   data_ok/rdata                                              : SRAM response side
//   flush                                                      : exception / ERTN cancel
//   out_valid/out_ready/out_data/out_info                      : MEM->WB side
//   outstanding                                                : requests not yet answered
// Build option: define MEMQ_LDEXT_EN to align/extend load data here (load_ext);
// otherwise out_data carries the raw SRAM word.
module mem_load_queue
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned INFO_W = 64
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_push,
   output logic                    req_ready,
   input  logic                    req_load,
   input  logic [2:0]              req_type,
   input  logic [1:0]              req_addr_low,
   input  logic [INFO_W-1:0]       req_info,
   input  logic                    data_ok,
   input  logic [31:0]             rdata,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_data,
   output logic [INFO_W-1:0]       out_info,
   output logic [$clog2(DEPTH):0]  outstanding
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   // Discard counter has headroom: a flush can land on a non-zero remainder.
   localparam int unsigned DW = PW + 2;
   localparam logic [DW:0] OUT_MAX = (DW+1)'((1 << CW) - 1);

   mq_entry_t         ents  [DEPTH];
   logic [INFO_W-1:0] infos [DEPTH];

   logic [PW-1:0] head, tail, resp;
   logic [CW-1:0] occ;       // valid slots
   logic [CW-1:0] pend;      // valid slots still waiting for data_ok
   logic [DW-1:0] discard;   // responses still owed to cancelled requests

   logic          push_acc, push_ok, fill, drop, pop;
   logic          no_discard;
   logic [DW:0]   flush_sum, out_sum;
   logic [DW-1:0] discard_flush;
   logic [31:0]   head_raw, head_fmt;
   mq_entry_t     new_ent;

   always_comb begin
      req_ready  = (occ != CW'(DEPTH));
      push_acc   = req_push & req_ready;
      push_ok    = push_acc & ~flush;
      no_discard = (discard == '0);
      drop       = data_ok & ~no_discard;
      fill       = data_ok & no_discard & (pend != '0) & ~flush;

      // Bypass: the response for a waiting head goes straight to WB.
      out_valid = ~flush & ents[head].valid &
                  (ents[head].arrived | (data_ok & no_discard & (resp == head)));
      pop       = out_valid & out_ready;

      // Every request issued but unanswered becomes a discard; this cycle's
      // data_ok answers one of them.
      flush_sum = (DW+1)'(discard) + (DW+1)'(pend) + (DW+1)'(push_acc);
      if (data_ok && flush_sum != '0)
         flush_sum = flush_sum - 1'b1;
      discard_flush = flush_sum[DW] ? '1 : flush_sum[DW-1:0];

      out_sum     = (DW+1)'(discard) + (DW+1)'(pend);
      outstanding = (out_sum > OUT_MAX) ? '1 : out_sum[CW-1:0];

      new_ent          = '0;
      new_ent.valid    = 1'b1;
      new_ent.load     = req_load;
      new_ent.mtype    = req_type;
      new_ent.addr_low = req_addr_low;

      head_raw = ents[head].arrived ? ents[head].data : rdata;
   end

`ifdef MEMQ_LDEXT_EN
   logic [2:0] head_type;
   logic [1:0] head_addr;

   always_comb begin
      head_type = ents[head].mtype;
      head_addr = ents[head].addr_low;
   end

   load_ext u_load_ext (
      .mtype    (head_type),
      .addr_low (head_addr),
      .rdata    (head_raw),
      .data     (head_fmt)
   );
`else
   always_comb head_fmt = head_raw;
`endif

   always_comb begin
      out_data = (out_valid & ents[head].load) ? head_fmt : '0;
      out_info = out_valid ? infos[head] : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         resp    <= '0;
         occ     <= '0;
         pend    <= '0;
         discard <= '0;
         for (int unsigned i = 0; i < DEPTH; i++)
            ents[i] <= '0;
      end else if (flush) begin
         head    <= '0;
         tail    <= '0;
         resp    <= '0;
         occ     <= '0;
         pend    <= '0;
         discard <= discard_flush;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ents[i].valid   <= 1'b0;
            ents[i].arrived <= 1'b0;
         end
      end else begin
         if (push_ok) begin
            ents[tail] <= new_ent;
            tail       <= tail + 1'b1;
         end
         if (fill) begin
            ents[resp].arrived <= 1'b1;
            ents[resp].data    <= rdata;
            resp               <= resp + 1'b1;
         end
         // Pop after fill: a bypassed head is filled and retired in one cycle.
         if (pop) begin
            ents[head].valid <= 1'b0;
            head             <= head + 1'b1;
         end
         if (drop)
            discard <= discard - 1'b1;
         occ  <= occ + CW'(push_ok) - CW'(pop);
         pend <= pend + CW'(push_ok) - CW'(fill);
      end
   end

   // Payload needs no reset: it is only observed through a valid slot.
   always_ff @(posedge clk) begin
      if (push_ok)
         infos[tail] <= req_info;
   end

endmodule
